// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath and the sequencer that drives it:
// op encoding, sequencer states and {Z,N,V,C} flag bit positions.
package alu_pkg;

    typedef logic [3:0] op_t;

    localparam op_t OP_ADD = 4'h0;
    localparam op_t OP_SUB = 4'h1;
    localparam op_t OP_AND = 4'h2;
    localparam op_t OP_OR  = 4'h3;
    localparam op_t OP_XOR = 4'h4;
    localparam op_t OP_SLL = 4'h5;
    localparam op_t OP_SLR = 4'h6;
    localparam op_t OP_SAR = 4'h7;
    localparam op_t OP_SC  = 4'h8;
    localparam op_t OP_MAX = OP_SC;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } seq_state_t;

    // Bit positions inside the 4-bit flag vector {Z,N,V,C}.
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

    function automatic logic op_is_valid(input op_t op);
        return op <= OP_MAX;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational n-bit ALU. Carry on SUB means "no borrow"; SC is a signed
// set-on-less-than. Logic ops and shifts clear V and C.
module alu
    import alu_pkg::*;
#(
    parameter int n = 3
) (
    input  logic [n-1:0] i_a,
    input  logic [n-1:0] i_b,
    input  op_t          i_ctrl,
    output logic [n-1:0] o_result,
    output logic         o_z,
    output logic         o_n,
    output logic         o_v,
    output logic         o_c
);

    logic [n:0] w_sum;

    always_comb begin
        w_sum    = '0;
        o_result = '0;
        o_v      = 1'b0;
        o_c      = 1'b0;
        case (i_ctrl)
            OP_ADD: begin
                w_sum    = {1'b0, i_a} + {1'b0, i_b};
                o_result = w_sum[n-1:0];
                o_c      = w_sum[n];
                o_v      = (i_a[n-1] == i_b[n-1]) && (w_sum[n-1] != i_a[n-1]);
            end
            OP_SUB: begin
                w_sum    = {1'b0, i_a} + {1'b0, ~i_b} + (n+1)'(1);
                o_result = w_sum[n-1:0];
                o_c      = w_sum[n];
                o_v      = (i_a[n-1] != i_b[n-1]) && (w_sum[n-1] != i_a[n-1]);
            end
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            OP_XOR:  o_result = i_a ^ i_b;
            OP_SLL:  o_result = i_a << i_b;
            OP_SLR:  o_result = i_a >> i_b;
            OP_SAR:  o_result = n'($signed(i_a) >>> i_b);
            OP_SC:   o_result = n'($signed(i_a) < $signed(i_b));
            default: o_result = '0;
        endcase
    end

    assign o_z = (o_result == '0);
    assign o_n = o_result[n-1];

endmodule

// File: rtl/alu_sequencer.sv
// Command/response sequencer for an external combinational ALU: one request
// in flight, registered ALU operands, one settle cycle, then a held response.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int n = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [n-1:0] req_a,
    input  logic [n-1:0] req_b,
    input  op_t          req_op,
    input  logic         req_chain,
    output logic [n-1:0] alu_a,
    output logic [n-1:0] alu_b,
    output op_t          alu_ctrl,
    input  logic [n-1:0] alu_result,
    input  logic         alu_z,
    input  logic         alu_n,
    input  logic         alu_v,
    input  logic         alu_c,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [n-1:0] rsp_result,
    output logic [3:0]   rsp_flags,
    output logic         rsp_err,
    output logic [7:0]   op_count,
    output seq_state_t   o_dbg_state
);

    seq_state_t   r_state;
    logic         r_req_ready;
    logic [n-1:0] r_alu_a;
    logic [n-1:0] r_alu_b;
    op_t          r_alu_ctrl;
    logic         r_rsp_valid;
    logic [n-1:0] r_rsp_result;
    logic [3:0]   r_rsp_flags;
    logic         r_rsp_err;
    logic [7:0]   r_op_count;
    logic [n-1:0] r_chain_val;
    logic [3:0]   w_flags;
    logic         w_req_fire;

    always_comb begin
        w_flags         = '0;
        w_flags[FLAG_Z] = alu_z;
        w_flags[FLAG_N] = alu_n;
        w_flags[FLAG_V] = alu_v;
        w_flags[FLAG_C] = alu_c;
    end

    // Both channels are valid/ready: a transfer happens on a rising edge where
    // valid && ready; the sender holds its payload stable while valid is
    // high and ready is low. req_ready is only high in IDLE, rsp_valid only in RESP.
    assign w_req_fire = req_valid && r_req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_req_ready  <= 1'b1;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_ctrl   <= OP_ADD;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_rsp_err    <= 1'b0;
            r_op_count   <= '0;
            r_chain_val  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_fire) begin
                        r_req_ready <= 1'b0;
                        if (op_is_valid(req_op)) begin
                            r_alu_a    <= req_chain ? r_chain_val : req_a;
                            r_alu_b    <= req_b;
                            r_alu_ctrl <= req_op;
                            r_state    <= ISSUE;
                        end else begin
                            // Undefined op: answer immediately, ALU never driven.
                            r_rsp_valid  <= 1'b1;
                            r_rsp_err    <= 1'b1;
                            r_rsp_result <= '0;
                            r_rsp_flags  <= '0;
                            r_state      <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    r_state <= CAPTURE;
                end
                CAPTURE: begin
                    r_rsp_valid  <= 1'b1;
                    r_rsp_err    <= 1'b0;
                    r_rsp_result <= alu_result;
                    r_rsp_flags  <= w_flags;
                    r_chain_val  <= alu_result;
                    r_op_count   <= r_op_count + 8'd1;
                    r_alu_a      <= '0;
                    r_alu_b      <= '0;
                    r_alu_ctrl   <= OP_ADD;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = r_req_ready;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_ctrl    = r_alu_ctrl;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_result  = r_rsp_result;
    assign rsp_flags   = r_rsp_flags;
    assign rsp_err     = r_rsp_err;
    assign op_count    = r_op_count;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer driving the shared 3-bit ALU.
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [N-1:0] req_a = '0;
    logic [N-1:0] req_b = '0;
    op_t          req_op = OP_ADD;
    logic         req_chain = 1'b0;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    op_t          alu_ctrl;
    logic [N-1:0] alu_result;
    logic         alu_z, alu_n, alu_v, alu_c;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [N-1:0] rsp_result;
    logic [3:0]   rsp_flags;
    logic         rsp_err;
    logic [7:0]   op_count;
    seq_state_t   dbg_state;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.n(N)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_chain(req_chain),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result),
        .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v), .alu_c(alu_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
        .op_count(op_count), .o_dbg_state(dbg_state)
    );

    alu #(.n(N)) u_alu (
        .i_a(alu_a), .i_b(alu_b), .i_ctrl(alu_ctrl),
        .o_result(alu_result),
        .o_z(alu_z), .o_n(alu_n), .o_v(alu_v), .o_c(alu_c)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request with rsp_ready low until the response is seen, then one accept cycle.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input op_t op,
                         input logic chain, input logic [N-1:0] exp_alu_a,
                         input logic [N-1:0] exp_res, input logic [3:0] exp_flags,
                         input logic err);
        req_a = a; req_b = b; req_op = op; req_chain = chain; req_valid = 1'b1;
        check("idle_req_ready", req_ready, 1);
        step();
        req_valid = 1'b0;
        if (err) begin
            check("err_rsp_valid", rsp_valid, 1);
            check("err_rsp_err", rsp_err, 1);
            check("err_rsp_result", rsp_result, 0);
            check("err_rsp_flags", rsp_flags, 0);
            check("err_alu_ctrl", alu_ctrl, 0);
            check("err_req_ready", req_ready, 0);
        end else begin
            exp_count++;
            check("issue_rsp_valid", rsp_valid, 0);
            check("issue_alu_a", alu_a, exp_alu_a);
            check("issue_alu_b", alu_b, b);
            check("issue_alu_ctrl", alu_ctrl, op);
            check("issue_req_ready", req_ready, 0);
            step();
            check("capture_rsp_valid", rsp_valid, 0);
            check("capture_alu_a", alu_a, exp_alu_a);
            check("capture_alu_ctrl", alu_ctrl, op);
            step();
            check("resp_rsp_valid", rsp_valid, 1);
            check("resp_rsp_err", rsp_err, 0);
            check("resp_rsp_result", rsp_result, exp_res);
            check("resp_rsp_flags", rsp_flags, exp_flags);
            check("resp_alu_a", alu_a, 0);
        end
        check("resp_op_count", op_count, 8'(exp_count));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("done_rsp_valid", rsp_valid, 0);
        check("done_req_ready", req_ready, 1);
    endtask

    initial begin
        step();
        step();
        rst = 1'b0;
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_result", rsp_result, 0);
        check("rst_rsp_flags", rsp_flags, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_op_count", op_count, 0);
        check("rst_alu_a", alu_a, 0);
        check("rst_alu_ctrl", alu_ctrl, 0);
        check("rst_state", 8'(dbg_state), 8'(IDLE));

        // ADD 3+2 overflows the signed range: Z=0 N=1 V=1 C=0.
        do_op(3'd3, 3'd2, OP_ADD, 1'b0, 3'd3, 3'd5, 4'b0110, 1'b0);
        do_op(3'd2, 3'd2, OP_SUB, 1'b0, 3'd2, 3'd0, 4'b1001, 1'b0);
        // Chained: req_a ignored, operand a is the previous result 0.
        do_op(3'd7, 3'd1, OP_ADD, 1'b1, 3'd0, 3'd1, 4'b0000, 1'b0);
        do_op(3'd5, 3'd5, 4'hF, 1'b0, 3'd0, 3'd0, 4'b0000, 1'b1);
        // Error response leaves the chain value at 1.
        do_op(3'd0, 3'd2, OP_ADD, 1'b1, 3'd1, 3'd3, 4'b0000, 1'b0);
        do_op(3'd4, 3'd1, OP_OR,  1'b0, 3'd4, 3'd5, 4'b0100, 1'b0);
        do_op(3'd5, 3'd5, OP_XOR, 1'b0, 3'd5, 3'd0, 4'b1000, 1'b0);
        do_op(3'd3, 3'd1, OP_SLL, 1'b0, 3'd3, 3'd6, 4'b0100, 1'b0);
        do_op(3'd6, 3'd1, OP_SLR, 1'b0, 3'd6, 3'd3, 4'b0000, 1'b0);
        do_op(3'd4, 3'd1, OP_SAR, 1'b0, 3'd4, 3'd6, 4'b0100, 1'b0);
        do_op(3'd7, 3'd1, OP_SC,  1'b0, 3'd7, 3'd1, 4'b0000, 1'b0);
        do_op(3'd1, 3'd7, OP_SC,  1'b0, 3'd1, 3'd0, 4'b1000, 1'b0);
        do_op(3'd0, 3'd1, OP_SUB, 1'b0, 3'd0, 3'd7, 4'b0100, 1'b0);
        do_op(3'd7, 3'd1, OP_ADD, 1'b0, 3'd7, 3'd0, 4'b1001, 1'b0);
        do_op(3'd1, 3'd1, 4'h9,   1'b0, 3'd0, 3'd0, 4'b0000, 1'b1);

        // Backpressure: response held 5 cycles, a new request is not taken.
        req_a = 3'd1; req_b = 3'd2; req_op = OP_OR; req_chain = 1'b0; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        step();
        exp_count++;
        req_a = 3'd5; req_b = 3'd3; req_op = OP_XOR; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", rsp_valid, 1);
            check("bp_rsp_result", rsp_result, 3);
            check("bp_rsp_flags", rsp_flags, 0);
            check("bp_req_ready", req_ready, 0);
            check("bp_op_count", op_count, 8'(exp_count));
            step();
        end
        rsp_ready = 1'b1;
        step();
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check("bp_done_rsp_valid", rsp_valid, 0);
        check("bp_done_req_ready", req_ready, 1);
        check("bp_done_alu_ctrl", alu_ctrl, 0);
        step();
        check("bp_not_taken_alu_ctrl", alu_ctrl, 0);
        check("bp_not_taken_req_ready", req_ready, 1);
        check("bp_not_taken_op_count", op_count, 8'(exp_count));

        // rsp_ready held high outside RESP does not shorten the sequence.
        rsp_ready = 1'b1;
        req_a = 3'd6; req_b = 3'd3; req_op = OP_AND; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        check("rr_issue_rsp_valid", rsp_valid, 0);
        step();
        check("rr_capture_rsp_valid", rsp_valid, 0);
        step();
        exp_count++;
        check("rr_resp_rsp_valid", rsp_valid, 1);
        check("rr_resp_result", rsp_result, 2);
        check("rr_resp_op_count", op_count, 8'(exp_count));
        step();
        rsp_ready = 1'b0;
        check("rr_done_rsp_valid", rsp_valid, 0);
        check("rr_done_req_ready", req_ready, 1);

        // Reset during CAPTURE wins over a pending response and a new request.
        req_a = 3'd1; req_b = 3'd1; req_op = OP_ADD; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        check("mid_state_capture", 8'(dbg_state), 8'(CAPTURE));
        rst = 1'b1; rsp_ready = 1'b1; req_valid = 1'b1;
        step();
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_op_count", op_count, 0);
        check("mid_rst_alu_a", alu_a, 0);
        check("mid_rst_alu_ctrl", alu_ctrl, 0);
        check("mid_rst_rsp_result", rsp_result, 0);
        check("mid_rst_rsp_flags", rsp_flags, 0);
        rst = 1'b0; rsp_ready = 1'b0; req_valid = 1'b0;
        exp_count = 0;
        check("mid_rst_req_ready", req_ready, 1);
        do_op(3'd7, 3'd3, OP_ADD, 1'b1, 3'd0, 3'd3, 4'b0000, 1'b0);

        // 256 good ops from reset: op_count wraps back to 0.
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_count = 0;
        for (int i = 0; i < 256; i++) begin
            do_op(3'd1, 3'd1, OP_ADD, 1'b0, 3'd1, 3'd2, 4'b0000, 1'b0);
        end
        check("wrap_op_count_zero", op_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter n, default 3, giving the operand and result width in bits, matching the ALU datapath width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, with synchronous, active-high reset sampled on rising clk.
REQ-004 SHALL have ports req_valid (in, 1), req_ready (out, 1), req_a (in, n), req_b (in, n), req_op (in, 4), req_chain (in, 1), forming the command channel.
REQ-005 SHALL have ports alu_a (out, n), alu_b (out, n), alu_ctrl (out, 4), alu_result (in, n), alu_z, alu_n, alu_v, alu_c (in, 1 each), connecting to an external combinational ALU instance.
REQ-006 SHALL have ports rsp_valid (out, 1), rsp_ready (in, 1), rsp_result (out, n), rsp_flags (out, 4, order {Z,N,V,C}), rsp_err (out, 1), forming the response channel.
REQ-007 SHALL have port op_count (out, 8), the count of successfully completed (non-error) operations.

Function
REQ-008 SHALL implement FSM states IDLE, ISSUE, CAPTURE, RESP.
REQ-009 SHALL assert req_ready only in IDLE; a handshake occurs when req_valid && req_ready.
REQ-010 SHALL on handshake latch a, b, op and chain, then go to ISSUE, or go directly to RESP with rsp_err=1, rsp_result=0 and rsp_flags=0 if op > 4'h8.
REQ-011 SHALL, when chain=1, use the last captured non-error result as the operand a (not req_a); after reset that value is 0.
REQ-012 SHALL drive alu_a, alu_b and alu_ctrl from registers, holding them stable in ISSUE and CAPTURE and at 0 in all other states.
REQ-013 SHALL in ISSUE allow one settle cycle, then go to CAPTURE.
REQ-014 SHALL in CAPTURE register alu_result and the flags into rsp_result and rsp_flags, update the chain register, increment op_count, and go to RESP.
REQ-015 SHALL, for a request accepted at edge T, have rsp_valid high from edge T+3 (error path: T+1).
REQ-016 SHALL in RESP hold rsp_valid=1 with stable rsp_* until rsp_ready=1, then go to IDLE on that edge; rsp_ready while not in RESP SHALL be ignored.
REQ-017 SHALL make back-to-back throughput 1 op per 4 cycles minimum; no new request is accepted in the same cycle as the response completes.
REQ-018 SHALL let op_count wrap from 255 to 0; error responses SHALL NOT increment it.
REQ-019 SHALL pass op codes through to alu_ctrl unchanged, using the shared encoding ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SLR=6, SAR=7, SC=8.

Reset
REQ-020 SHALL, with rst=1 at any state including mid-operation, next edge: state IDLE, req_ready=1 after release, rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_err=0, alu_* outputs 0, op_count=0, chain register 0; any pending response SHALL be discarded.
REQ-021 SHALL give rst priority over every handshake in the same cycle.

Structure
REQ-022 SHALL place the op code constants, the 4-bit op type, the state enum and the flag bit indices in package alu_pkg, shared with the ALU.
REQ-023 SHALL contain no sub-module; the ALU is instantiated alongside it by the enclosing top, and the bench SHALL use the existing ALU with n=3.

Verification
REQ-024 SHALL cover reset then ADD a=3, b=2 accepted at T -> rsp_valid at T+3, result=5, flags Z=0, N=1 (bit2 set), V=1, C=0, op_count=1.
REQ-025 SHALL cover SUB a=2, b=2 -> result=0, Z=1, C=1; then chained ADD b=1 -> alu_a=0, result=1.
REQ-026 SHALL cover op=4'hF -> rsp_err=1 at T+1, result=0, op_count unchanged, alu_ctrl stays 0.
REQ-027 SHALL cover rsp_ready held low 5 cycles -> rsp_* stable, req_ready=0 throughout; req_valid asserted meanwhile is not accepted.
REQ-028 SHALL cover 256 non-error ops -> op_count wraps to 0.
REQ-029 SHALL cover rst asserted during CAPTURE -> next cycle rsp_valid=0, op_count=0, chain register 0, req_ready=1 after release.
